gemm_c_writeback: RTL and testbench
===================================

// Module: gemm_c_writeback
// PURPOSE
//  Output drain stage downstream of the RowPar x ColPar MAC array in gemm_accelerator_top.
//  Accepts one finished accumulator tile per handshake and saturates each element to OutWidth.
//  Writes the tile row by row into SRAM C: one word per row, ColPar results, row-major.
//  Counts tiles per GEMM and pulses done_o after the last row of the last tile is written.
// PARAMETERS
//  RowPar        4   rows per tile (MAC array height)
//  ColPar        16  columns per tile (MAC array width); one C word = ColPar results
//  AccWidth      32  signed accumulator width per element
//  OutWidth      32  signed stored width per element; must be <= AccWidth
//  AddrWidth     12  SRAM C word address width
//  SizeAddrWidth 32  width of M/N size inputs
// PORTS
//  clk_i          in   1                        clock, rising edge
//  rst_i          in   1                        synchronous, active-high reset
//  start_i        in   1                        latch M/N sizes, arm a new GEMM (honoured in IDLE only)
//  M_size_i       in   SizeAddrWidth            rows of C (any value >= 1)
//  N_size_i       in   SizeAddrWidth            cols of C (multiple of ColPar, >= ColPar)
//  tile_valid_i   in   1                        tile_data_i/tile_m_i/tile_n_i valid
//  tile_ready_o   out  1                        stage can capture a tile this cycle
//  tile_m_i       in   SizeAddrWidth            tile row index (row block, units of RowPar)
//  tile_n_i       in   SizeAddrWidth            tile col index (col block, units of ColPar)
//  tile_data_i    in   RowPar*ColPar*AccWidth   [r][c] signed accumulators
//  sram_c_addr_o  out  AddrWidth                C word address
//  sram_c_wdata_o out  ColPar*OutWidth          [c] saturated results; element 0 in LSBs
//  sram_c_we_o    out  1                        write strobe
//  busy_o         out  1                        high in every state except IDLE
//  done_o         out  1                        one-cycle pulse: all tiles written
// BEHAVIOUR
//  Reset: state=IDLE; tile_ready_o=0, sram_c_we_o=0, sram_c_addr_o=0, sram_c_wdata_o=0, busy_o=0, done_o=0.
//  Reset mid-operation: same values next cycle; captured tile discarded, no further writes.
//  FSM IDLE -> (start_i) WAIT. Latch M and N.
//    NB = N/ColPar.
//    tiles_total = ceil(M/RowPar)*NB.
//    tile_cnt = 0.
//  WAIT: tile_ready_o=1. On valid&&ready: capture data/m/n into tile buffer, row_cnt=0 -> DRAIN.
//  DRAIN: one row per cycle, row_cnt 0..RowPar-1, exactly RowPar cycles per tile.
//    addr = (tile_m*RowPar + row_cnt)*NB + tile_n, truncated to AddrWidth.
//    we = 1 iff tile_m*RowPar+row_cnt < M; padding rows consume the cycle with we=0.
//    tile_ready_o=1 only on row_cnt==RowPar-1 and tile_cnt+1 < tiles_total (back-to-back, no bubble).
//      Accept in that cycle: buffer reloads, row_cnt=0, stay DRAIN.
//    Last row, no accept: tile_cnt+1==tiles_total -> DONE, else -> WAIT.
//  DONE: done_o=1 for one cycle, tile_ready_o=0 -> IDLE.
//  Outputs are registered: write of row r appears on the SRAM port in the cycle DRAIN holds row_cnt=r.
//    Capture->first write latency = 1 cycle.
//  Saturation per element, signed:
//    x > 2^(OutWidth-1)-1 -> max; x < -2^(OutWidth-1) -> min; else truncate.
//    OutWidth==AccWidth: pass-through.
//  tile_valid_i while tile_ready_o=0: tile held upstream, never dropped or double-captured.
//  start_i outside IDLE: ignored. start_i with tile_valid_i in IDLE: only the start is taken.
//  Tiles out of order or repeated: no reordering; written where indexed, still counted once each.
//  sram_c_wdata_o holds its last value when we=0; checkers consider it only when we=1.
// STRUCTURE
//  Package gemm_wb_pkg:
//    state enum {IDLE, WAIT, DRAIN, DONE}
//    function sat_to_out(AccWidth signed) -> OutWidth
//    localparams RowCntWidth = $clog2(RowPar) and TileCntWidth.
//  One sub-module: gemm_wb_sat_row, combinational; ColPar saturators for one buffered row.
//  Top: FSM, counters, address multiply-add, tile buffer and output registers.
// TESTING
//  1 M=4,N=16, one tile, m=n=0, data[r][c]=r*16+c -> writes addr 0..3 on 4 consecutive cycles, data match; done_o 1 cycle after addr3.
//  2 M=8,N=32, 4 tiles back-to-back valid -> 16 writes with no gap; addr=(m*4+r)*2+n; tile_ready_o high only on row 3; single done_o.
//  3 M=6,N=16, 2 tiles -> rows 6,7 of tile m=1 give we=0; exactly 6 writes; done after 8 drain cycles.
//  4 OutWidth=8, element values 300/-300/127/-128 -> stored 127/-128/127/-128.
//  5 rst_i pulsed during DRAIN row 1 -> next cycle we=0, ready=0, busy=0; new start and tile then run cleanly.
//  6 Random valid gaps and start_i during DRAIN -> start ignored; golden C (random 8-bit A,B) matches the SRAM dump.

Source files
------------

// File: rtl/gemm_wb_pkg.sv
// rtl/gemm_wb_pkg.sv - shared types, widths and saturation helper for the C writeback stage
package gemm_wb_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, DRAIN, DONE} state_t;

    // Counter widths track the default array geometry; change together with RowPar.
    localparam int DefRowPar    = 4;
    localparam int RowCntWidth  = $clog2(DefRowPar);
    localparam int TileCntWidth = 32;

    // Clamp a sign-extended accumulator into an out_w-bit signed range (out_w < 64).
    function automatic logic signed [63:0] sat_to_out(input logic signed [63:0] x, input int out_w);
        logic signed [63:0] mx;
        logic signed [63:0] mn;
        mx = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        mn = -mx - 64'sd1;
        if (x > mx) return mx;
        if (x < mn) return mn;
        return x;
    endfunction

endpackage

// File: rtl/gemm_wb_sat_row.sv
// rtl/gemm_wb_sat_row.sv - ColPar signed saturators for one buffered accumulator row
module gemm_wb_sat_row
    import gemm_wb_pkg::*;
#(
    parameter int ColPar   = 16,
    parameter int AccWidth = 32,
    parameter int OutWidth = 32
) (
    input  logic [ColPar*AccWidth-1:0] row_acc,
    output logic [ColPar*OutWidth-1:0] row_sat
);

    for (genvar c = 0; c < ColPar; c++) begin : g_col
        if (OutWidth == AccWidth) begin : g_pass
            assign row_sat[c*OutWidth +: OutWidth] = row_acc[c*AccWidth +: AccWidth];
        end else begin : g_sat
            assign row_sat[c*OutWidth +: OutWidth] =
                OutWidth'(sat_to_out(64'($signed(row_acc[c*AccWidth +: AccWidth])), OutWidth));
        end
    end

endmodule

// File: rtl/gemm_c_writeback.sv
// rtl/gemm_c_writeback.sv - drains accumulator tiles row by row into SRAM C, one word per row
module gemm_c_writeback
    import gemm_wb_pkg::*;
#(
    parameter int RowPar        = DefRowPar,
    parameter int ColPar        = 16,
    parameter int AccWidth      = 32,
    parameter int OutWidth      = 32,
    parameter int AddrWidth     = 12,
    parameter int SizeAddrWidth = 32
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              start_i,
    input  logic [SizeAddrWidth-1:0]          M_size_i,
    input  logic [SizeAddrWidth-1:0]          N_size_i,
    input  logic                              tile_valid_i,
    output logic                              tile_ready_o,
    input  logic [SizeAddrWidth-1:0]          tile_m_i,
    input  logic [SizeAddrWidth-1:0]          tile_n_i,
    input  logic [RowPar*ColPar*AccWidth-1:0] tile_data_i,
    output logic [AddrWidth-1:0]              sram_c_addr_o,
    output logic [ColPar*OutWidth-1:0]        sram_c_wdata_o,
    output logic                              sram_c_we_o,
    output logic                              busy_o,
    output logic                              done_o
);

    localparam int RowW  = ColPar * AccWidth;
    localparam int WordW = ColPar * OutWidth;

    state_t                       state, state_n;
    logic [RowCntWidth-1:0]       row_cnt, row_cnt_n;
    logic [TileCntWidth-1:0]      tile_cnt, tiles_total;
    logic [SizeAddrWidth-1:0]     m_size, nb, buf_m, buf_n;
    logic [RowPar*RowW-1:0]       tile_buf;
    logic                         accept, last_row, more_tiles, drain_n, we_n;
    logic [SizeAddrWidth-1:0]     row_m_n, row_n_n, row_idx, addr_full;
    logic [RowW-1:0]              row_acc;
    logic [WordW-1:0]             row_sat;

    assign last_row     = (row_cnt == RowCntWidth'(RowPar - 1));
    assign more_tiles   = (tile_cnt + TileCntWidth'(1)) < tiles_total;
    assign tile_ready_o = (state == WAIT) || (state == DRAIN && last_row && more_tiles);
    assign accept       = tile_valid_i && tile_ready_o;
    assign busy_o       = (state != IDLE);
    assign done_o       = (state == DONE);

    // Next-cycle row selection: output registers load the row the FSM is about to present.
    always_comb begin
        state_n   = state;
        row_cnt_n = row_cnt;
        drain_n   = 1'b0;
        case (state)
            IDLE:  if (start_i) state_n = WAIT;
            WAIT:  if (accept) begin
                       state_n   = DRAIN;
                       row_cnt_n = '0;
                       drain_n   = 1'b1;
                   end
            DRAIN: if (!last_row) begin
                       row_cnt_n = row_cnt + RowCntWidth'(1);
                       drain_n   = 1'b1;
                   end else if (accept) begin
                       row_cnt_n = '0;
                       drain_n   = 1'b1;
                   end else begin
                       state_n = more_tiles ? WAIT : DONE;
                   end
            DONE:  state_n = IDLE;
            default: state_n = IDLE;
        endcase

        if (accept) begin
            row_acc = tile_data_i[RowW-1:0];
            row_m_n = tile_m_i;
            row_n_n = tile_n_i;
        end else begin
            row_acc = tile_buf[int'(row_cnt_n)*RowW +: RowW];
            row_m_n = buf_m;
            row_n_n = buf_n;
        end

        row_idx   = row_m_n * SizeAddrWidth'(RowPar) + SizeAddrWidth'(row_cnt_n);
        addr_full = row_idx * nb + row_n_n;
        we_n      = drain_n && (row_idx < m_size);
    end

    gemm_wb_sat_row #(
        .ColPar  (ColPar),
        .AccWidth(AccWidth),
        .OutWidth(OutWidth)
    ) u_sat (
        .row_acc(row_acc),
        .row_sat(row_sat)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state          <= IDLE;
            row_cnt        <= '0;
            tile_cnt       <= '0;
            tiles_total    <= '0;
            m_size         <= '0;
            nb             <= '0;
            sram_c_addr_o  <= '0;
            sram_c_wdata_o <= '0;
            sram_c_we_o    <= 1'b0;
        end else begin
            state       <= state_n;
            row_cnt     <= row_cnt_n;
            sram_c_we_o <= we_n;
            if (we_n) begin
                sram_c_addr_o  <= addr_full[AddrWidth-1:0];
                sram_c_wdata_o <= row_sat;
            end
            if (state == IDLE && start_i) begin
                m_size      <= M_size_i;
                nb          <= N_size_i / SizeAddrWidth'(ColPar);
                tiles_total <= TileCntWidth'(((M_size_i + SizeAddrWidth'(RowPar - 1)) / SizeAddrWidth'(RowPar))
                                             * (N_size_i / SizeAddrWidth'(ColPar)));
                tile_cnt    <= '0;
            end else if (state == DRAIN && last_row) begin
                tile_cnt <= tile_cnt + TileCntWidth'(1);
            end
        end
    end

    // Tile buffer needs no reset: it is only read after a fresh capture.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            tile_buf <= tile_data_i;
            buf_m    <= tile_m_i;
            buf_n    <= tile_n_i;
        end
    end

endmodule

// File: tb/tb_gemm_c_writeback.sv
// tb/tb_gemm_c_writeback.sv - directed self-checking bench for gemm_c_writeback
module tb_gemm_c_writeback;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [31:0]   m_size = '0, n_size = '0;
    logic          tile_valid = 1'b0;
    logic [31:0]   tile_m = '0, tile_n = '0;
    logic [2047:0] tile_data = '0;

    logic          tile_ready, sram_we, busy, done;
    logic [11:0]   sram_addr;
    logic [511:0]  sram_wdata;
    logic          tile_ready8, sram_we8, busy8, done8;
    logic [11:0]   sram_addr8;
    logic [127:0]  sram_wdata8;

    gemm_c_writeback dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .M_size_i(m_size), .N_size_i(n_size),
        .tile_valid_i(tile_valid), .tile_ready_o(tile_ready), .tile_m_i(tile_m), .tile_n_i(tile_n),
        .tile_data_i(tile_data), .sram_c_addr_o(sram_addr), .sram_c_wdata_o(sram_wdata),
        .sram_c_we_o(sram_we), .busy_o(busy), .done_o(done)
    );

    gemm_c_writeback #(.OutWidth(8)) dut8 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .M_size_i(m_size), .N_size_i(n_size),
        .tile_valid_i(tile_valid), .tile_ready_o(tile_ready8), .tile_m_i(tile_m), .tile_n_i(tile_n),
        .tile_data_i(tile_data), .sram_c_addr_o(sram_addr8), .sram_c_wdata_o(sram_wdata8),
        .sram_c_we_o(sram_we8), .busy_o(busy8), .done_o(done8)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int           wa[$];
    logic [511:0] wd[$];
    int           wc[$];
    logic [127:0] w8[$];
    int           dc[$];
    int           rc[$];

    always @(negedge clk) begin
        if (sram_we) begin
            wa.push_back(int'(sram_addr));
            wd.push_back(sram_wdata);
            wc.push_back(cyc);
        end
        if (sram_we8) w8.push_back(sram_wdata8);
        if (done) dc.push_back(cyc);
        if (tile_ready) rc.push_back(cyc);
    end

    int total = 0;
    int bad   = 0;

    task automatic start_gemm(input int m, input int n);
        start = 1'b1; m_size = m; n_size = n;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_tile(input int m, input int n, input logic [2047:0] d);
        bit ok;
        ok = 1'b0;
        tile_valid = 1'b1; tile_m = m; tile_n = n; tile_data = d;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tile_ready) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        tile_valid = 1'b0;
        total++;
        if (!ok) begin bad++; $display("FAIL handshake m=%0d n=%0d accepted=%0d required=1", m, n, ok); end
    endtask

    task automatic wait_done(input int base);
        for (int i = 0; i < 300; i++) begin
            if (dc.size() > base) break;
            @(posedge clk);
        end
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (dc.size() != base + 1) begin
            bad++; $display("FAIL done_count got=%0d required=%0d", dc.size() - base, 1);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total += 7;
        if (tile_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b required=0", tile_ready); end
        if (sram_we !== 1'b0)    begin bad++; $display("FAIL reset_we got=%b required=0", sram_we); end
        if (sram_addr !== 12'd0) begin bad++; $display("FAIL reset_addr got=%0h required=0", sram_addr); end
        if (sram_wdata !== '0)   begin bad++; $display("FAIL reset_wdata got=%0h required=0", sram_wdata); end
        if (busy !== 1'b0)       begin bad++; $display("FAIL reset_busy got=%b required=0", busy); end
        if (done !== 1'b0)       begin bad++; $display("FAIL reset_done got=%b required=0", done); end
        if (sram_wdata8 !== '0)  begin bad++; $display("FAIL reset_wdata8 got=%0h required=0", sram_wdata8); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_single_tile();
        logic [2047:0] td;
        logic [511:0]  w;
        int b, bd;
        b = wa.size(); bd = dc.size();
        td = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 16; c++) td[(r*16+c)*32 +: 32] = r*16 + c;
        start_gemm(4, 16);
        send_tile(0, 0, td);
        wait_done(bd);
        total++;
        if (wa.size() - b != 4) begin bad++; $display("FAIL t1_writes got=%0d required=4", wa.size() - b); end
        if (wa.size() - b >= 4) begin
            for (int r = 0; r < 4; r++) begin
                w = wd[b+r];
                total += 2;
                if (wa[b+r] != r) begin bad++; $display("FAIL t1_addr row=%0d got=%0d required=%0d", r, wa[b+r], r); end
                if (wc[b+r] != wc[b] + r) begin bad++; $display("FAIL t1_gap row=%0d got=%0d required=%0d", r, wc[b+r], wc[b] + r); end
                for (int c = 0; c < 16; c++) begin
                    total++;
                    if (w[c*32 +: 32] !== 32'(r*16 + c)) begin
                        bad++; $display("FAIL t1_data r=%0d c=%0d got=%0d required=%0d", r, c, w[c*32 +: 32], r*16 + c);
                    end
                end
            end
            total++;
            if (dc.size() > bd && dc[bd] != wc[b+3] + 1) begin
                bad++; $display("FAIL t1_done_cycle got=%0d required=%0d", dc[bd], wc[b+3] + 1);
            end
        end
    endtask

    task automatic test_back_to_back();
        int tm[4] = '{0, 0, 1, 1};
        int tn[4] = '{0, 1, 0, 1};
        logic [2047:0] td;
        logic [511:0]  w;
        int b, bd, br, nrdy, e;
        b = wa.size(); bd = dc.size(); br = rc.size();
        start_gemm(8, 32);
        for (int t = 0; t < 4; t++) begin
            td = '0;
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 16; c++) td[(r*16+c)*32 +: 32] = t*1000 + r*16 + c;
            send_tile(tm[t], tn[t], td);
        end
        wait_done(bd);
        total++;
        if (wa.size() - b != 16) begin bad++; $display("FAIL t2_writes got=%0d required=16", wa.size() - b); end
        if (wa.size() - b >= 16) begin
            for (int i = 0; i < 16; i++) begin
                w = wd[b+i];
                e = (tm[i/4]*4 + i%4)*2 + tn[i/4];
                total += 3;
                if (wa[b+i] != e) begin bad++; $display("FAIL t2_addr i=%0d got=%0d required=%0d", i, wa[b+i], e); end
                if (wc[b+i] != wc[b] + i) begin bad++; $display("FAIL t2_gap i=%0d got=%0d required=%0d", i, wc[b+i], wc[b] + i); end
                if (w[5*32 +: 32] !== 32'((i/4)*1000 + (i%4)*16 + 5)) begin
                    bad++; $display("FAIL t2_data i=%0d got=%0d required=%0d", i, w[5*32 +: 32], (i/4)*1000 + (i%4)*16 + 5);
                end
            end
            nrdy = 0;
            for (int k = br; k < rc.size(); k++) begin
                if (rc[k] >= wc[b]) begin
                    total++;
                    if (rc[k] != wc[b] + nrdy*4 + 3) begin
                        bad++; $display("FAIL t2_ready_cycle got=%0d required=%0d", rc[k], wc[b] + nrdy*4 + 3);
                    end
                    nrdy++;
                end
            end
            total++;
            if (nrdy != 3) begin bad++; $display("FAIL t2_ready_count got=%0d required=3", nrdy); end
        end
    endtask

    task automatic test_padding();
        logic [2047:0] td;
        int b, bd;
        b = wa.size(); bd = dc.size();
        start_gemm(6, 16);
        for (int t = 0; t < 2; t++) begin
            td = '0;
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 16; c++) td[(r*16+c)*32 +: 32] = 7000 + t*100 + r;
            send_tile(t, 0, td);
        end
        wait_done(bd);
        total++;
        if (wa.size() - b != 6) begin bad++; $display("FAIL t3_writes got=%0d required=6", wa.size() - b); end
        if (wa.size() - b >= 6) begin
            for (int i = 0; i < 6; i++) begin
                total++;
                if (wa[b+i] != i) begin bad++; $display("FAIL t3_addr i=%0d got=%0d required=%0d", i, wa[b+i], i); end
            end
            total++;
            if (dc.size() > bd && dc[bd] != wc[b] + 8) begin
                bad++; $display("FAIL t3_done_cycle got=%0d required=%0d", dc[bd], wc[b] + 8);
            end
        end
    endtask

    task automatic test_saturation();
        logic signed [31:0] pat[6] = '{300, -300, 127, -128, 5, -5};
        logic [7:0]         exp8[6] = '{8'h7f, 8'h80, 8'h7f, 8'h80, 8'h05, 8'hfb};
        logic [2047:0] td;
        logic [127:0]  w;
        int b, bd;
        b = w8.size(); bd = dc.size();
        td = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 16; c++) td[(r*16+c)*32 +: 32] = pat[(r + c) % 6];
        start_gemm(4, 16);
        send_tile(0, 0, td);
        wait_done(bd);
        total++;
        if (w8.size() - b != 4) begin bad++; $display("FAIL t4_writes got=%0d required=4", w8.size() - b); end
        if (w8.size() - b >= 4) begin
            for (int r = 0; r < 4; r++) begin
                w = w8[b+r];
                for (int c = 0; c < 16; c++) begin
                    total++;
                    if (w[c*8 +: 8] !== exp8[(r + c) % 6]) begin
                        bad++; $display("FAIL t4_sat r=%0d c=%0d got=%0h required=%0h", r, c, w[c*8 +: 8], exp8[(r + c) % 6]);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [2047:0] td;
        logic [511:0]  w;
        int b, bd;
        b = wa.size();
        td = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 16; c++) td[(r*16+c)*32 +: 32] = 900 + r*16 + c;
        start_gemm(4, 16);
        send_tile(0, 0, td);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        total += 4;
        if (sram_we !== 1'b0)    begin bad++; $display("FAIL t5_we got=%b required=0", sram_we); end
        if (tile_ready !== 1'b0) begin bad++; $display("FAIL t5_ready got=%b required=0", tile_ready); end
        if (busy !== 1'b0)       begin bad++; $display("FAIL t5_busy got=%b required=0", busy); end
        if (sram_addr !== 12'd0) begin bad++; $display("FAIL t5_addr got=%0d required=0", sram_addr); end
        repeat (6) @(posedge clk);
        #1;
        total++;
        if (wa.size() - b != 2) begin bad++; $display("FAIL t5_writes_before_reset got=%0d required=2", wa.size() - b); end
        b = wa.size(); bd = dc.size();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 16; c++) td[(r*16+c)*32 +: 32] = 1500 + r*16 + c;
        start_gemm(4, 16);
        send_tile(0, 0, td);
        wait_done(bd);
        total++;
        if (wa.size() - b != 4) begin bad++; $display("FAIL t5_writes_after got=%0d required=4", wa.size() - b); end
        if (wa.size() - b >= 4) begin
            for (int r = 0; r < 4; r++) begin
                w = wd[b+r];
                total += 2;
                if (wa[b+r] != r) begin bad++; $display("FAIL t5_addr row=%0d got=%0d required=%0d", r, wa[b+r], r); end
                if (w[15*32 +: 32] !== 32'(1500 + r*16 + 15)) begin
                    bad++; $display("FAIL t5_data row=%0d got=%0d required=%0d", r, w[15*32 +: 32], 1500 + r*16 + 15);
                end
            end
        end
    endtask

    task automatic test_random_golden();
        int tm[4] = '{1, 0, 1, 0};
        int tn[4] = '{1, 0, 0, 1};
        int a[6][4];
        int bm[4][32];
        int cm[6][32];
        logic [2047:0] td;
        logic [511:0]  w;
        logic [11:0]   seen;
        int b, bd, row, col, ad;
        for (int i = 0; i < 6; i++)
            for (int k = 0; k < 4; k++) a[i][k] = int'($urandom_range(0, 255)) - 128;
        for (int k = 0; k < 4; k++)
            for (int j = 0; j < 32; j++) bm[k][j] = int'($urandom_range(0, 255)) - 128;
        for (int i = 0; i < 6; i++)
            for (int j = 0; j < 32; j++) begin
                cm[i][j] = 0;
                for (int k = 0; k < 4; k++) cm[i][j] += a[i][k] * bm[k][j];
            end
        b = wa.size(); bd = dc.size();
        start_gemm(6, 32);
        for (int t = 0; t < 4; t++) begin
            td = '0;
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 16; c++) begin
                    row = tm[t]*4 + r;
                    td[(r*16+c)*32 +: 32] = (row < 6) ? cm[row][tn[t]*16 + c] : 32'hDEAD0000 + c;
                end
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            send_tile(tm[t], tn[t], td);
            if (t == 0) begin
                start = 1'b1; m_size = 99; n_size = 48;
                @(negedge clk);
                total++;
                if (busy !== 1'b1) begin bad++; $display("FAIL t6_busy_on_start got=%b required=1", busy); end
                @(posedge clk); #1;
                start = 1'b0;
            end
        end
        wait_done(bd);
        total++;
        if (wa.size() - b != 12) begin bad++; $display("FAIL t6_writes got=%0d required=12", wa.size() - b); end
        seen = '0;
        for (int i = b; i < wa.size(); i++) begin
            ad = wa[i];
            w  = wd[i];
            total++;
            if (ad >= 12) begin
                bad++; $display("FAIL t6_addr_range got=%0d required=<12", ad);
            end else begin
                seen[ad] = 1'b1;
                for (int c = 0; c < 16; c++) begin
                    total++;
                    if (w[c*32 +: 32] !== 32'(cm[ad/2][(ad%2)*16 + c])) begin
                        bad++; $display("FAIL t6_golden addr=%0d c=%0d got=%0d required=%0d", ad, c, $signed(w[c*32 +: 32]), cm[ad/2][(ad%2)*16 + c]);
                    end
                end
            end
        end
        col = 0;
        total++;
        if (seen !== 12'hfff) begin bad++; $display("FAIL t6_coverage got=%0h required=fff", seen); end
    endtask

    initial begin
        test_reset();
        test_single_tile();
        test_back_to_back();
        test_padding();
        test_saturation();
        test_reset_mid();
        test_random_golden();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
